// File: rtl/seq_mult_8b_pkg.sv
// seq_mult_8b_pkg: shared definitions for the sequential 8x8 multiplier.
//   state_t   : controller state encoding. The ALU controller uses these names
//               for its stall logic, so the values are fixed.
//   COUNT_W   : width of the iteration counter.
//   ITER_LAST : counter value of the final iteration.
package seq_mult_8b_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned    COUNT_W   = 3;
  localparam logic [COUNT_W-1:0] ITER_LAST = 3'd7;

endpackage : seq_mult_8b_pkg

// File: rtl/adder_8b.sv
// adder_8b: 8-bit ripple-carry adder shared across the ALU datapath.
//   a, b : addends
//   cin  : carry in
//   sum  : 8-bit sum
//   cout : carry out
module adder_8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic carry;

  // NOTE: every output of a combinational block gets a value on every path
  // before it is used, so no latch can be inferred.
  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < 8; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule : adder_8b

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: FSM and iteration counter for the sequential multiplier.
//   clk, reset : clock and synchronous active-high reset
//   start      : multiply request, honoured only in IDLE
//   busy       : registered, high while in CALC
//   done       : registered, one-cycle pulse in DONE
//   load       : accept strobe (IDLE and start), datapath captures operands
//   step       : high in CALC, datapath performs one iteration
//   last       : high on the final iteration, datapath captures the product
module seq_mult_ctrl
  import seq_mult_8b_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  output logic load,
  output logic step,
  output logic last
);

  state_t             state;
  logic [COUNT_W-1:0] count;

  // Strobes decode the state register only; start merely qualifies load.
  assign load = (state == ST_IDLE) && start;
  assign step = (state == ST_CALC);
  assign last = (state == ST_CALC) && (count == ITER_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= ST_CALC;
            count <= '0;
            busy  <= 1'b1;
          end
        end
        ST_CALC: begin
          count <= count + 1'b1;
          if (count == ITER_LAST) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          // start is deliberately ignored here.
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          // Encoding 2'd3 is unreachable; recover to IDLE.
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule : seq_mult_ctrl

// File: rtl/seq_mult_8b.sv
// seq_mult_8b: unsigned 8x8 shift-and-add multiplier, one add per clock.
//   clk, reset   : clock and synchronous active-high reset
//   start        : multiply request, sampled only in IDLE
//   multiplicand : operand M, captured on the accepting edge
//   multiplier   : operand Q, captured on the accepting edge
//   busy         : high during the 8 iteration cycles
//   done         : one-cycle pulse when product becomes valid
//   product      : 16-bit registered result, held until next completion/reset
module seq_mult_8b
  import seq_mult_8b_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ITER  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // The datapath is hard-wired to adder_8b.
  if (WIDTH != 8 || ITER != WIDTH) begin : g_cfg_error
    $error("seq_mult_8b supports only WIDTH=8, ITER=8");
  end

  logic [7:0] a;      // accumulator
  logic [7:0] q;      // multiplier / low product bits
  logic [7:0] m;      // multiplicand
  logic       c;      // 9th accumulator bit
  logic       load;
  logic       step;
  logic       last;

  logic [7:0] add_sum;
  logic       add_cout;
  logic [7:0] s;
  logic       c_n;

  seq_mult_ctrl u_ctrl (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .load  (load),
    .step  (step),
    .last  (last)
  );

  adder_8b u_add (
    .a    (a),
    .b    (m),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Partial-product select: add M only when the current multiplier bit is 1.
  always_comb begin
    if (q[0]) {c_n, s} = {add_cout, add_sum};
    else      {c_n, s} = {c, a};
  end

  // NOTE: all datapath registers are plain flops, so each gets an explicit
  // reset value; there is no storage array here that would need to skip it.
  always_ff @(posedge clk) begin
    if (reset) begin
      a       <= '0;
      q       <= '0;
      m       <= '0;
      c       <= 1'b0;
      product <= '0;
    end else if (load) begin
      m <= multiplicand;
      q <= multiplier;
      a <= '0;
      c <= 1'b0;
    end else if (step) begin
      // {C,A,Q} shifted right by one: the carry lands in A[7] and is cleared.
      a <= {c_n, s[7:1]};
      q <= {s[0], q[7:1]};
      c <= 1'b0;
      if (last) product <= {c_n, s, q[7:1]};
    end
  end

endmodule : seq_mult_8b
